program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream stage of the CPU in the system: on a start pulse, copies a program image from a read-only source into RAM, then signals completion so system control can move from LOADING to EXECUTING.
- Owns the RAM write port during load; the CPU must not drive RAM until done.
- Streams one word per cycle and reports a load checksum and word count for bench and debug checks.

Parameters:
- DATA_WIDTH, 16, instruction/data word width.
- ADDR_WIDTH, 16, RAM and source address width.
- LOAD_BASE, 0, RAM address of the first loaded word.
- MAX_WORDS, 256, maximum words per load; longer requests are clamped.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- start  in  1  load request, sampled each cycle; ignored unless IDLE.
- length  in  ADDR_WIDTH  number of words to load; sampled with start.
- src_en  out  1  source read enable.
- src_addr  out  ADDR_WIDTH  source word index.
- src_data  in  DATA_WIDTH  source data, valid exactly 1 cycle after src_en.
- mem_write  out  1  RAM write strobe.
- mem_addr  out  ADDR_WIDTH  RAM write address.
- mem_write_data  out  DATA_WIDTH  RAM write data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at load completion.
- clamped  out  1  sticky flag: the last request exceeded MAX_WORDS.
- words_loaded  out  ADDR_WIDTH  count of RAM writes in the current or last load.
- checksum  out  DATA_WIDTH  modulo-2^DATA_WIDTH sum of all written words.

Behaviour:
- Reset (reset==0 at an edge): state IDLE. All outputs 0: src_en, src_addr, mem_write, mem_addr, mem_write_data, busy, done, clamped, words_loaded, checksum.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE, start=1 at edge E0:
  - Latch n = min(length, MAX_WORDS); clamped <= (length > MAX_WORDS).
  - Clear words_loaded and checksum; busy <= 1.
  - If n==0, go to DONE. Otherwise go to STREAM with rd_idx=0.
- STREAM, cycle k = 0..n-1 after E0:
  - src_en=1 and src_addr=k.
  - From cycle 1 onward, mem_write=1, mem_addr=LOAD_BASE+(k-1), mem_write_data=src_data (word k-1).
  - After issuing read n-1, go to DRAIN.
- DRAIN, one cycle:
  - src_en=0; write word n-1 to LOAD_BASE+n-1; go to DONE.
- Every write cycle: words_loaded += 1; checksum += mem_write_data, wrapping with carry dropped.
- DONE, one cycle:
  - done=1, busy=0, mem_write=0; return to IDLE.
  - words_loaded, checksum and clamped hold until the next accepted start or reset.
- Timing: throughput is 1 word/cycle. First write occurs 2 cycles after E0 and the last at E0+n+1. done is high in the cycle after the last write. For n==0, done is high in the cycle after E0 with no writes.
- Address arithmetic: LOAD_BASE+idx wraps modulo 2^ADDR_WIDTH; no error is flagged.
- start asserted while busy or in DONE is ignored; it is not queued.
- start held high continuously: a new load is accepted on the first IDLE cycle after done.
- Reset mid-load aborts immediately. The next cycle has mem_write=0. RAM keeps any words already written. No done pulse is issued.
- mem_write, src_en and done are never high in the same cycle as reset==0 takes effect.

Decomposition:
- Shared package (e.g. system_pkg): loader state encoding, DATA_WIDTH/ADDR_WIDTH defaults, and the system_state encodings (IDLE/LOADING/EXECUTING) so system control and the loader agree.
- No sub-module. The read/write pipeline register (one data stage plus write-address register) is small and stays inline.

Test Plan:
- Basic load: LOAD_BASE=0, length=4, source words 1111/2222/3333/4444 -> writes at addr 0..3 on cycles E0+2..E0+5; done one cycle later; words_loaded=4; checksum=AAAA.
- Zero length: start with length=0 -> no src_en, no mem_write; done pulse at E0+1; words_loaded=0; checksum=0000.
- Clamp and wrap: MAX_WORDS=4, length=6, source words FFFF x4 -> exactly 4 writes; clamped=1; checksum=FFFC.
- Base offset and wrap: LOAD_BASE=FFFE, length=3 -> writes at FFFE, FFFF, 0000.
- Start while busy: second start pulse at E0+2 of a length-4 load -> ignored; single done; a start after done begins a fresh load with counters cleared.
- Reset mid-load: length=8, reset=0 at E0+4 -> mem_write=0 next cycle; RAM addr 0..2 hold the loaded words and addr 3..7 are untouched; no done; all outputs 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: loader FSM encoding, width defaults and system control state encoding
package program_loader_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 16;
  typedef enum logic [1:0] {LD_IDLE, LD_STREAM, LD_DRAIN, LD_DONE} loader_state_t;
  typedef enum logic [1:0] {SYS_IDLE, SYS_LOADING, SYS_EXECUTING} system_state_t;
endpackage

// File: rtl/program_loader.sv
// program_loader: streams a program image from a read-only source into RAM, one word per cycle
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE = '0,
  parameter int MAX_WORDS = 256
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  src_en,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  clamped,
  output logic [ADDR_WIDTH-1:0] words_loaded,
  output logic [DATA_WIDTH-1:0] checksum
);
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  loader_state_t state, state_next;
  logic [ADDR_WIDTH-1:0] n, rd_idx, wr_addr, len_n;
  logic wr_valid, accept, last_rd;
  always_comb begin
    len_n = length > MAX_N ? MAX_N : length;
    accept = state == LD_IDLE && start;
    last_rd = rd_idx == n - ONE;
    state_next = state == LD_IDLE ? (start ? (len_n == '0 ? LD_DONE : LD_STREAM) : LD_IDLE)
      : state == LD_STREAM ? (last_rd ? LD_DRAIN : LD_STREAM)
      : state == LD_DRAIN ? LD_DONE : LD_IDLE;
    src_en = state == LD_STREAM;
    src_addr = rd_idx;
    busy = state == LD_STREAM || state == LD_DRAIN;
    done = state == LD_DONE;
    mem_write = wr_valid;
    mem_addr = wr_addr;
    mem_write_data = wr_valid ? src_data : '0;
  end
  // the write stage trails the read by one cycle, matching the source's 1-cycle read latency
  always_ff @(posedge clock)
    if (!reset) begin
      state <= LD_IDLE;
      n <= '0;
      rd_idx <= '0;
      wr_addr <= '0;
      wr_valid <= 1'b0;
      clamped <= 1'b0;
      words_loaded <= '0;
      checksum <= '0;
    end else begin
      state <= state_next;
      wr_valid <= state == LD_STREAM;
      if (state == LD_STREAM) begin
        rd_idx <= rd_idx + ONE;
        wr_addr <= LOAD_BASE + rd_idx;
      end
      if (wr_valid) begin
        words_loaded <= words_loaded + ONE;
        checksum <= checksum + mem_write_data;
      end
      if (accept) begin
        n <= len_n;
        rd_idx <= '0;
        clamped <= length > MAX_N;
        words_loaded <= '0;
        checksum <= '0;
      end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: two loader instances (base 0/max 256, base FFFE/max 4) checked against a write scoreboard
module tb_program_loader;
  typedef struct {
    int len;
    bit ramp;
    logic [0:3][15:0] w;
    logic [0:1][15:0] words;
    logic [0:1][15:0] ck;
    logic [0:1] cl;
  } vec_t;
  typedef struct {
    int cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0] length = '0;
  logic src_en [2], mem_write [2], busy [2], done [2], clamped [2];
  logic [15:0] src_addr [2], src_data [2], mem_addr [2], mem_write_data [2], words_loaded [2], checksum [2];
  logic [15:0] rom [256];
  logic [15:0] ram0 [65536];
  logic [15:0] ram1 [65536];
  wr_t wq0 [$], wq1 [$];
  int dq0 [$], dq1 [$];
  int cyc_n = 0, total = 0, passed = 0;
  int rd_cnt [2], busy_cnt [2];
  bit mon_en = 1'b0;
  vec_t tbl [5];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    program_loader #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16),
      .LOAD_BASE(g ? 16'hFFFE : 16'h0000), .MAX_WORDS(g ? 4 : 256)
    ) dut (
      .clock(clock), .reset(reset), .start(start), .length(length),
      .src_en(src_en[g]), .src_addr(src_addr[g]), .src_data(src_data[g]),
      .mem_write(mem_write[g]), .mem_addr(mem_addr[g]), .mem_write_data(mem_write_data[g]),
      .busy(busy[g]), .done(done[g]), .clamped(clamped[g]),
      .words_loaded(words_loaded[g]), .checksum(checksum[g])
    );
  end

  initial forever #5 clock = ~clock;

  // source model: data valid exactly one cycle after the enable, garbage otherwise
  always @(posedge clock)
    for (int i = 0; i < 2; i++) src_data[i] <= src_en[i] ? rom[src_addr[i][7:0]] : 16'hDEAD;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic int maxw(input int d);
    return d != 0 ? 4 : 256;
  endfunction

  function automatic logic [15:0] base(input int d);
    return d != 0 ? 16'hFFFE : 16'h0000;
  endfunction

  function automatic vec_t mk(input int len, input bit ramp, input logic [63:0] w,
                              input logic [31:0] words, input logic [31:0] ck, input logic [1:0] cl);
    vec_t v;
    v.len = len;
    v.ramp = ramp;
    v.w = w;
    v.words = words;
    v.ck = ck;
    v.cl = cl;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name);
    total++;
    $display("FAIL %s", name);
  endtask

  task automatic monitor();
    wr_t e;
    int dc;
    for (int d = 0; d < 2; d++) begin
      if (src_en[d]) rd_cnt[d]++;
      if (busy[d]) busy_cnt[d]++;
      if (mem_write[d]) begin
        if (d == 0) ram0[mem_addr[d]] = mem_write_data[d];
        else ram1[mem_addr[d]] = mem_write_data[d];
        if ((d == 0 ? wq0.size() : wq1.size()) == 0)
          flag($sformatf("unexpected_write%0d: got write at cycle %0d addr %0h expected none", d, cyc_n, mem_addr[d]));
        else begin
          if (d == 0) e = wq0.pop_front();
          else e = wq1.pop_front();
          check($sformatf("wr_addr%0d", d), mem_addr[d], e.addr);
          check($sformatf("wr_data%0d", d), mem_write_data[d], e.data);
          check($sformatf("wr_cycle%0d", d), cyc_n, e.cyc);
        end
      end
      if (done[d]) begin
        if ((d == 0 ? dq0.size() : dq1.size()) == 0)
          flag($sformatf("unexpected_done%0d: got done at cycle %0d expected none", d, cyc_n));
        else begin
          if (d == 0) dc = dq0.pop_front();
          else dc = dq1.pop_front();
          check($sformatf("done_cycle%0d", d), cyc_n, dc);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cyc_n++;
    if (mon_en) monitor();
  endtask

  task automatic push(input int d, input wr_t e);
    if (d == 0) wq0.push_back(e);
    else wq1.push_back(e);
  endtask

  task automatic push_done(input int d, input int c);
    if (d == 0) dq0.push_back(c);
    else dq1.push_back(c);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_ctl%0d", tag, d), {src_en[d], mem_write[d], busy[d], done[d], clamped[d]}, 5'b0);
      check($sformatf("%s_bus%0d", tag, d),
            {src_addr[d], mem_addr[d], mem_write_data[d], words_loaded[d], checksum[d]}, 80'b0);
    end
  endtask

  task automatic check_drained(input string tag);
    check($sformatf("%s_left0", tag), wq0.size() + dq0.size(), 0);
    check($sformatf("%s_left1", tag), wq1.size() + dq1.size(), 0);
  endtask

  task automatic run_load(input vec_t v, input int poke);
    int n [2];
    int c0, t;
    for (int i = 0; i < 256; i++) rom[i] = v.ramp ? 16'(i) : v.w[i % 4];
    start = 1'b1;
    length = 16'(v.len);
    c0 = cyc_n + 1;
    for (int d = 0; d < 2; d++) begin
      n[d] = v.len > maxw(d) ? maxw(d) : v.len;
      rd_cnt[d] = 0;
      busy_cnt[d] = 0;
      for (int k = 0; k < n[d]; k++) push(d, '{c0 + k + 1, base(d) + 16'(k), rom[k]});
      push_done(d, n[d] == 0 ? c0 : c0 + n[d] + 1);
    end
    tick();
    for (t = 0; t < 400 && wq0.size() + wq1.size() + dq0.size() + dq1.size() > 0; t++) begin
      start = t == poke;
      tick();
    end
    start = 1'b0;
    repeat (3) tick();
    check_drained($sformatf("len%0d", v.len));
    for (int d = 0; d < 2; d++) begin
      check($sformatf("len%0d_words%0d", v.len, d), words_loaded[d], v.words[d]);
      check($sformatf("len%0d_cksum%0d", v.len, d), checksum[d], v.ck[d]);
      check($sformatf("len%0d_clamped%0d", v.len, d), clamped[d], v.cl[d]);
      check($sformatf("len%0d_reads%0d", v.len, d), rd_cnt[d], n[d]);
      check($sformatf("len%0d_busy_cycles%0d", v.len, d), busy_cnt[d], n[d] > 0 ? n[d] + 1 : 0);
      check($sformatf("len%0d_busy_end%0d", v.len, d), busy[d], 1'b0);
    end
  endtask

  initial begin
    int c0;
    tbl[0] = mk(4, 1'b0, 64'h1111_2222_3333_4444, 32'h0004_0004, 32'hAAAA_AAAA, 2'b00);
    tbl[1] = mk(0, 1'b0, 64'h1111_2222_3333_4444, 32'h0000_0000, 32'h0000_0000, 2'b00);
    tbl[2] = mk(6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0006_0004, 32'hFFFA_FFFC, 2'b01);
    tbl[3] = mk(3, 1'b0, 64'h0001_0010_0100_1000, 32'h0003_0003, 32'h0111_0111, 2'b00);
    tbl[4] = mk(300, 1'b1, 64'h0, 32'h0100_0004, 32'h7F80_0006, 2'b11);
    repeat (2) tick();
    check_zero("reset");
    reset = 1'b1;
    mon_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) run_load(tbl[i], -1);
    run_load(mk(4, 1'b0, 64'h1111_2222_3333_4444, 32'h0004_0004, 32'hAAAA_AAAA, 2'b00), 1);
    run_load(mk(2, 1'b0, 64'h0102_0304_0000_0000, 32'h0002_0002, 32'h0406_0406, 2'b00), -1);
    // abort a length-8 load after three writes have landed
    for (int i = 0; i < 16; i++) begin
      ram0[i] = 16'h5A5A;
      ram1[i] = 16'h5A5A;
    end
    ram1[16'hFFFE] = 16'h5A5A;
    ram1[16'hFFFF] = 16'h5A5A;
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000 + 16'(i);
    start = 1'b1;
    length = 16'd8;
    c0 = cyc_n + 1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) push(d, '{c0 + k + 1, base(d) + 16'(k), rom[k]});
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_zero("abort");
    reset = 1'b1;
    repeat (4) tick();
    check_drained("abort");
    for (int i = 0; i < 3; i++) check($sformatf("abort_ram0_%0d", i), ram0[i], 16'hA000 + 16'(i));
    for (int i = 3; i < 8; i++) check($sformatf("abort_ram0_%0d", i), ram0[i], 16'h5A5A);
    check("abort_ram1_fffe", ram1[16'hFFFE], 16'hA000);
    check("abort_ram1_ffff", ram1[16'hFFFF], 16'hA001);
    check("abort_ram1_0", ram1[0], 16'hA002);
    check("abort_ram1_1", ram1[1], 16'h5A5A);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
